// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Time-shares one combinational ALU between the integer EX stage (port 0)
// and the multi-cycle FP/convert unit (port 1). Port 0 wins by default.
// A starvation counter moves port 1 to the front once it has been blocked
// for MAX_WAIT cycles. Each port has a one-entry registered response slot
// with a valid/ready handshake.
module alu_share_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             reset,
  // port 0 request (integer EX stage)
  input  logic             req0_valid,
  input  logic [4:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  // port 1 request (FP / convert unit)
  input  logic             req1_valid,
  input  logic [4:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  // port 0 response
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_set,
  output logic             rsp0_zero,
  input  logic             rsp0_ready,
  // port 1 response
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_set,
  output logic             rsp1_zero,
  input  logic             rsp1_ready,
  // shared ALU
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_set,
  input  logic             alu_zero
);

  typedef enum logic {
    NORMAL = 1'b0,
    STARVE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
  localparam logic [4:0]       OP_AND  = 5'b00000;

  state_t             state_q;
  logic [CNT_W-1:0]   starve_cnt_q;
  logic [CNT_W-1:0]   cnt_inc;

  logic [1:0]         req_valid;
  logic [1:0]         rsp_ready;
  logic [1:0]         slot_free;
  logic [1:0]         eligible;
  logic [1:0]         grant;

  logic [1:0]         rsp_valid_q;
  logic [1:0]         rsp_set_q;
  logic [1:0]         rsp_zero_q;
  logic [WIDTH-1:0]   rsp_result_q [2];

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // A slot can accept a new result when empty or being drained this cycle.
  // Grants are suppressed while reset is high so no transfer is lost.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign slot_free[gi] = !rsp_valid_q[gi] || rsp_ready[gi];
      assign eligible[gi]  = req_valid[gi] && slot_free[gi] && !reset;
    end
  endgenerate

  // Priority select: port 0 first normally, port 1 first while starving.
  always_comb begin
    grant = 2'b00;
    if (state_q == STARVE) begin
      if (eligible[1])      grant[1] = 1'b1;
      else if (eligible[0]) grant[0] = 1'b1;
    end else begin
      if (eligible[0])      grant[0] = 1'b1;
      else if (eligible[1]) grant[1] = 1'b1;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // Drive the ALU from the granted port; idle inputs give a fixed AND of zeros.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = OP_AND;
    if (grant[0]) begin
      alu_a  = req0_a;
      alu_b  = req0_b;
      alu_op = req0_op;
    end else if (grant[1]) begin
      alu_a  = req1_a;
      alu_b  = req1_b;
      alu_op = req1_op;
    end
  end

  // Saturating increment of the blocked-cycle count.
  assign cnt_inc = (starve_cnt_q == MAX_CNT) ? starve_cnt_q : starve_cnt_q + 1'b1;

  // Starvation FSM. Entering STARVE as the count reaches MAX_WAIT means port 1
  // wins on the cycle right after its MAX_WAIT-th blocked cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= NORMAL;
      starve_cnt_q <= '0;
    end else begin
      case (state_q)
        NORMAL: begin
          if (grant[1]) begin
            starve_cnt_q <= '0;
          end else if (req1_valid) begin
            starve_cnt_q <= cnt_inc;
            if (cnt_inc == MAX_CNT) state_q <= STARVE;
          end
        end
        STARVE: begin
          if (grant[1] || !req1_valid) begin
            state_q      <= NORMAL;
            starve_cnt_q <= '0;
          end else begin
            starve_cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q      <= NORMAL;
          starve_cnt_q <= '0;
        end
      endcase
    end
  end

  // Response slots: capture the ALU outputs at the end of a grant cycle,
  // empty on consumer accept without refill, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= '0;
      rsp_set_q   <= '0;
      rsp_zero_q  <= '0;
      for (int i = 0; i < 2; i++) rsp_result_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (grant[i]) begin
          rsp_valid_q[i]  <= 1'b1;
          rsp_result_q[i] <= alu_result;
          rsp_set_q[i]    <= alu_set;
          rsp_zero_q[i]   <= alu_zero;
        end else if (rsp_ready[i]) begin
          rsp_valid_q[i]  <= 1'b0;
        end
      end
    end
  end

  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp0_result = rsp_result_q[0];
  assign rsp0_set    = rsp_set_q[0];
  assign rsp0_zero   = rsp_zero_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp1_result = rsp_result_q[1];
  assign rsp1_set    = rsp_set_q[1];
  assign rsp1_zero   = rsp_zero_q[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed scenarios plus a randomized run
// against a behavioural model of the arbitration and response rules.
module tb_alu_share_arbiter;

  localparam int W        = 32;
  localparam int MAX_WAIT = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic [4:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         rsp0_valid, rsp0_set, rsp0_zero, rsp0_ready;
  logic         rsp1_valid, rsp1_set, rsp1_zero, rsp1_ready;
  logic [W-1:0] rsp0_result, rsp1_result;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [4:0]   alu_op;
  logic         alu_set, alu_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W), .MAX_WAIT(MAX_WAIT), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_set(rsp0_set),
    .rsp0_zero(rsp0_zero), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_set(rsp1_set),
    .rsp1_zero(rsp1_zero), .rsp1_ready(rsp1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_set(alu_set), .alu_zero(alu_zero)
  );

  // Stand-in ALU: returns {result, set, zero}.
  function automatic logic [W+1:0] alu_f(input logic [4:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         s;
    s = 1'b0;
    case (op)
      5'b00000: r = a & b;
      5'b00001: r = a | b;
      5'b00010: r = a + b;
      5'b00011: r = a - b;
      5'b01000: begin r = ($signed(a) < $signed(b)) ? 1 : 0; s = r[0]; end
      default:  r = a ^ b;
    endcase
    return {r, s, (r == '0)};
  endfunction

  always_comb {alu_result, alu_set, alu_zero} = alu_f(alu_op, alu_a, alu_b);

  function automatic logic [4:0] pick_op();
    case ($urandom_range(0, 4))
      0: return 5'b00000;
      1: return 5'b00001;
      2: return 5'b00010;
      3: return 5'b00011;
      default: return 5'b01000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready});
    end
    checks++;
    tick();
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_rsp_valid got %b want 00", {rsp0_valid, rsp1_valid});
    end
    checks++;
    if ({rsp0_result, rsp0_set, rsp0_zero, rsp1_result, rsp1_set, rsp1_zero} !== '0) begin
      errors++; $display("FAIL reset_rsp_fields got %h/%h want 0", rsp0_result, rsp1_result);
    end
    checks++;
    clear_inputs();
    reset = 0;
    tick();
    $display("reset: rsp0_valid=%b rsp1_valid=%b", rsp0_valid, rsp1_valid);
  endtask

  task automatic test_basic_add();
    do_reset();
    req0_valid = 1; req0_op = 5'b00010; req0_a = 5; req0_b = 7;
    @(negedge clk);
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL add_ready got %b%b want 10", req0_ready, req1_ready);
    end
    checks++;
    if (alu_a !== 5 || alu_b !== 7 || alu_op !== 5'b00010) begin
      errors++; $display("FAIL add_alu_mux got a=%0d b=%0d op=%b want 5 7 00010", alu_a, alu_b, alu_op);
    end
    checks++;
    tick();
    req0_valid = 0;
    if (rsp0_valid !== 1'b1 || rsp0_result !== 12 || rsp0_zero !== 1'b0) begin
      errors++; $display("FAIL add_rsp got v=%b r=%0d z=%b want 1 12 0", rsp0_valid, rsp0_result, rsp0_zero);
    end
    checks++;
    $display("add: 5+7 -> rsp0_result=%0d", rsp0_result);
  endtask

  // Runs on from test_basic_add: rsp0 holds 12 and is not accepted.
  task automatic test_backpressure();
    rsp0_ready = 0; rsp1_ready = 1;
    req0_valid = 1; req0_op = 5'b00011; req0_a = 9; req0_b = 1;
    req1_valid = 1; req1_op = 5'b00011; req1_a = 3; req1_b = 3;
    @(negedge clk);
    if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready got %b%b want 01", req0_ready, req1_ready);
    end
    checks++;
    tick();
    req1_valid = 0;
    if (rsp0_valid !== 1'b1 || rsp0_result !== 12 || rsp0_zero !== 1'b0) begin
      errors++; $display("FAIL bp_rsp0_hold got v=%b r=%0d want 1 12", rsp0_valid, rsp0_result);
    end
    checks++;
    if (rsp1_valid !== 1'b1 || rsp1_result !== 0 || rsp1_zero !== 1'b1) begin
      errors++; $display("FAIL bp_rsp1 got v=%b r=%0d z=%b want 1 0 1", rsp1_valid, rsp1_result, rsp1_zero);
    end
    checks++;
    $display("backpressure: rsp0 held %0d, rsp1 3-3=%0d zero=%b", rsp0_result, rsp1_result, rsp1_zero);
  endtask

  // Runs on from test_backpressure: req0 (9-1) still pending, rsp0 full.
  task automatic test_drain_refill();
    rsp0_ready = 1;
    @(negedge clk);
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL refill_ready got %b want 1", req0_ready);
    end
    checks++;
    tick();
    req0_valid = 0;
    if (rsp0_valid !== 1'b1 || rsp0_result !== 8) begin
      errors++; $display("FAIL refill_rsp got v=%b r=%0d want 1 8", rsp0_valid, rsp0_result);
    end
    checks++;
    tick();
    if (rsp0_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty got %b want 0", rsp0_valid);
    end
    checks++;
    $display("drain_refill: 9-1 -> rsp0_result=8 then drained");
  endtask

  task automatic test_idle_slt();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (alu_a !== '0 || alu_b !== '0 || alu_op !== 5'b00000) begin
        errors++; $display("FAIL idle_alu got a=%h b=%h op=%b want 0 0 00000", alu_a, alu_b, alu_op);
      end
      checks++;
      tick();
      if ({rsp0_valid, rsp1_valid, rsp0_result, rsp1_result} !== '0) begin
        errors++; $display("FAIL idle_rsp got v=%b%b want 00", rsp0_valid, rsp1_valid);
      end
      checks++;
    end
    req1_valid = 1; req1_op = 5'b01000; req1_a = 1; req1_b = 2;
    @(negedge clk);
    if (req1_ready !== 1'b1 || alu_op !== 5'b01000) begin
      errors++; $display("FAIL slt_grant got rdy=%b op=%b want 1 01000", req1_ready, alu_op);
    end
    checks++;
    tick();
    req1_valid = 0;
    if (rsp1_valid !== 1'b1 || rsp1_result !== 1 || rsp1_set !== 1'b1 || rsp1_zero !== 1'b0) begin
      errors++; $display("FAIL slt_rsp got r=%0d s=%b z=%b want 1 1 0", rsp1_result, rsp1_set, rsp1_zero);
    end
    checks++;
    $display("idle_slt: slt 1<2 -> rsp1_result=%0d set=%b", rsp1_result, rsp1_set);
  endtask

  // Both ports request continuously with open consumers: port 0 gets four
  // cycles, port 1 the fifth, repeating.
  task automatic run_rotation(input string tag, input int n);
    logic [W+1:0] e0, e1;
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req0_op = 5'b00010; req0_a = 10;    req0_b = 20;
    req1_valid = 1; req1_op = 5'b00001; req1_a = 'hF0; req1_b = 'h0F;
    e0 = alu_f(req0_op, req0_a, req0_b);
    e1 = alu_f(req1_op, req1_a, req1_b);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (req1_ready !== ((i % 5) == 4) || req0_ready !== ((i % 5) != 4)) begin
        errors++; $display("FAIL %s_grant cyc %0d got %b%b want %b%b", tag, i,
                           req0_ready, req1_ready, (i % 5) != 4, (i % 5) == 4);
      end
      checks++;
      tick();
      if ((i % 5) == 4) begin
        if (rsp1_valid !== 1'b1 || {rsp1_result, rsp1_set, rsp1_zero} !== e1) begin
          errors++; $display("FAIL %s_rsp1 cyc %0d got v=%b r=%h want 1 %h", tag, i, rsp1_valid, rsp1_result, e1[W+1:2]);
        end
      end else begin
        if (rsp0_valid !== 1'b1 || {rsp0_result, rsp0_set, rsp0_zero} !== e0) begin
          errors++; $display("FAIL %s_rsp0 cyc %0d got v=%b r=%h want 1 %h", tag, i, rsp0_valid, rsp0_result, e0[W+1:2]);
        end
      end
      checks++;
      $display("%s: cyc %0d granted port %0d", tag, i, ((i % 5) == 4) ? 1 : 0);
    end
    clear_inputs();
  endtask

  task automatic test_rotation();
    do_reset();
    run_rotation("rotation", 15);
  endtask

  task automatic test_reset_mid();
    do_reset();
    req1_valid = 1; req1_op = 5'b00010; req1_a = 100; req1_b = 1;
    tick();
    req1_op = 5'b00011; req1_a = 50; req1_b = 8;
    if (rsp1_valid !== 1'b1 || rsp1_result !== 101) begin
      errors++; $display("FAIL mid_rsp1 got v=%b r=%0d want 1 101", rsp1_valid, rsp1_result);
    end
    checks++;
    // rsp1 is full and not accepted: port 1 is blocked and starves.
    req0_valid = 1; req0_op = 5'b00010; req0_a = 2; req0_b = 2; rsp0_ready = 1;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(negedge clk);
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL mid_blocked cyc %0d got %b%b want 10", i, req0_ready, req1_ready);
      end
      checks++;
      tick();
    end
    reset = 1;
    @(negedge clk);
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL mid_reset_ready got %b want 00", {req0_ready, req1_ready});
    end
    checks++;
    tick();
    reset = 0;
    if (rsp1_valid !== 1'b0 || rsp0_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_flush got %b%b want 00", rsp0_valid, rsp1_valid);
    end
    checks++;
    $display("reset_mid: responses flushed, checking fresh rotation");
    run_rotation("post_reset", 5);
  endtask

  task automatic test_random();
    bit           m_starve;
    int           m_wait;
    bit           m_rv [2];
    logic [W+1:0] m_rsp [2];
    logic [W+1:0] got;
    bit           e0, e1, g0, g1;
    logic [W-1:0] xa, xb;
    logic [4:0]   xop;
    do_reset();
    m_starve = 0; m_wait = 0;
    m_rv[0] = 0; m_rv[1] = 0; m_rsp[0] = '0; m_rsp[1] = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (req1_valid && $urandom_range(0, 7) == 0) req1_valid = 0;
      else if (!req1_valid && $urandom_range(0, 2) != 0) begin
        req1_valid = 1; req1_op = pick_op();
        req1_a = $urandom_range(0, 3) == 0 ? W'($urandom_range(0, 4)) : $urandom;
        req1_b = $urandom_range(0, 3) == 0 ? W'($urandom_range(0, 4)) : $urandom;
      end
      if (!req0_valid && $urandom_range(0, 2) != 0) begin
        req0_valid = 1; req0_op = pick_op();
        req0_a = $urandom_range(0, 3) == 0 ? W'($urandom_range(0, 4)) : $urandom;
        req0_b = $urandom_range(0, 3) == 0 ? W'($urandom_range(0, 4)) : $urandom;
      end
      rsp0_ready = $urandom_range(0, 3) != 0;
      rsp1_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      e0 = req0_valid && (!m_rv[0] || rsp0_ready);
      e1 = req1_valid && (!m_rv[1] || rsp1_ready);
      if (m_starve) begin g1 = e1; g0 = e0 && !e1; end
      else          begin g0 = e0; g1 = e1 && !e0; end
      if (req0_ready !== g0 || req1_ready !== g1) begin
        errors++; $display("FAIL rnd_grant cyc %0d got %b%b want %b%b", cyc, req0_ready, req1_ready, g0, g1);
      end
      checks++;
      xa = g0 ? req0_a : g1 ? req1_a : '0;
      xb = g0 ? req0_b : g1 ? req1_b : '0;
      xop = g0 ? req0_op : g1 ? req1_op : 5'b00000;
      if (alu_a !== xa || alu_b !== xb || alu_op !== xop) begin
        errors++; $display("FAIL rnd_alu cyc %0d got %h %h %b want %h %h %b", cyc, alu_a, alu_b, alu_op, xa, xb, xop);
      end
      checks++;
      // model: response slots
      if (g0) begin m_rv[0] = 1; m_rsp[0] = alu_f(req0_op, req0_a, req0_b); end
      else if (rsp0_ready) m_rv[0] = 0;
      if (g1) begin m_rv[1] = 1; m_rsp[1] = alu_f(req1_op, req1_a, req1_b); end
      else if (rsp1_ready) m_rv[1] = 0;
      // model: port 1 waiting time and priority boost
      if (g1) begin m_wait = 0; m_starve = 0; end
      else if (req1_valid) begin
        m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
        if (m_wait == MAX_WAIT) m_starve = 1;
      end else if (m_starve) begin m_wait = 0; m_starve = 0; end
      tick();
      if (rsp0_valid !== m_rv[0]) begin
        errors++; $display("FAIL rnd_rsp0_valid cyc %0d got %b want %b", cyc, rsp0_valid, m_rv[0]);
      end
      checks++;
      if (rsp1_valid !== m_rv[1]) begin
        errors++; $display("FAIL rnd_rsp1_valid cyc %0d got %b want %b", cyc, rsp1_valid, m_rv[1]);
      end
      checks++;
      got = {rsp0_result, rsp0_set, rsp0_zero};
      if (m_rv[0] && got !== m_rsp[0]) begin
        errors++; $display("FAIL rnd_rsp0_data cyc %0d got %h want %h", cyc, got, m_rsp[0]);
      end
      if (m_rv[0]) checks++;
      got = {rsp1_result, rsp1_set, rsp1_zero};
      if (m_rv[1] && got !== m_rsp[1]) begin
        errors++; $display("FAIL rnd_rsp1_data cyc %0d got %h want %h", cyc, got, m_rsp[1]);
      end
      if (m_rv[1]) checks++;
      if (g0 || g1) $display("random: cyc %0d port %0d granted, starve=%0d wait=%0d", cyc, g1 ? 1 : 0, m_starve, m_wait);
      if (g0) req0_valid = 0;
      if (g1) req1_valid = 0;
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_basic_add();
    test_backpressure();
    test_drain_refill();
    test_idle_slt();
    test_rotation();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
